// File: rtl/button_event_decoder.sv
// button_event_decoder: turns a debounced switch level into single-cycle press/short/long/repeat/release events
//
// Ports:
//   i_Clk       system clock
//   i_Rst       asynchronous active-high reset
//   i_Switch    debounced switch level (polarity set by c_ACTIVE_HIGH)
//   i_Repeat_En enables auto-repeat pulses while held
//   o_Press     one-cycle pulse when a press is recognised
//   o_Short     one-cycle pulse on release before the long threshold (always with o_Release)
//   o_Long      one-cycle pulse when the long threshold is reached
//   o_Repeat    one-cycle auto-repeat pulse while held
//   o_Release   one-cycle pulse on any release
//   o_Pressed   level, high in PRESSED or HELD
//   o_Held      level, high in HELD
module button_event_decoder #(
    parameter int c_LONG_COUNT   = 50000000,
    parameter int c_REPEAT_COUNT = 10000000,
    parameter bit c_ACTIVE_HIGH  = 1'b1
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch,
    input  logic i_Repeat_En,
    output logic o_Press,
    output logic o_Short,
    output logic o_Long,
    output logic o_Repeat,
    output logic o_Release,
    output logic o_Pressed,
    output logic o_Held
);
    localparam int MAX_COUNT = (c_LONG_COUNT > c_REPEAT_COUNT) ? c_LONG_COUNT : c_REPEAT_COUNT;
    localparam int CW = $clog2(MAX_COUNT) + 1;
    localparam logic [CW-1:0] LONG_LAST   = CW'(c_LONG_COUNT - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(c_REPEAT_COUNT - 1);

    // three bits leave spare encodings so a corrupted state is caught by the default branch
    typedef enum logic [2:0] {ARM, IDLE, PRESSED, HELD} state_t;

    state_t        state;
    logic          sw_norm;
    logic          sw_q;
    logic          sampled;
    logic [CW-1:0] count;

    assign sw_norm = c_ACTIVE_HIGH ? i_Switch : ~i_Switch;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state     <= ARM;
            sw_q      <= 1'b0;
            sampled   <= 1'b0;
            count     <= '0;
            o_Press   <= 1'b0;
            o_Short   <= 1'b0;
            o_Long    <= 1'b0;
            o_Repeat  <= 1'b0;
            o_Release <= 1'b0;
            o_Pressed <= 1'b0;
            o_Held    <= 1'b0;
        end else begin
            sw_q      <= sw_norm;
            sampled   <= 1'b1;
            o_Press   <= 1'b0;
            o_Short   <= 1'b0;
            o_Long    <= 1'b0;
            o_Repeat  <= 1'b0;
            o_Release <= 1'b0;
            case (state)
                // sw_q still holds its reset value on the first edge, so wait for a real sample
                // before trusting it; otherwise a switch held through reset would look released
                ARM: begin
                    if (sampled && !sw_q) state <= IDLE;
                end
                IDLE: begin
                    if (sw_q) begin
                        state     <= PRESSED;
                        o_Press   <= 1'b1;
                        o_Pressed <= 1'b1;
                        count     <= '0;
                    end
                end
                // release is tested first so it beats the long threshold on the same edge
                PRESSED: begin
                    if (!sw_q) begin
                        state     <= IDLE;
                        o_Short   <= 1'b1;
                        o_Release <= 1'b1;
                        o_Pressed <= 1'b0;
                    end else if (count == LONG_LAST) begin
                        state  <= HELD;
                        o_Long <= 1'b1;
                        o_Held <= 1'b1;
                        count  <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                HELD: begin
                    if (!sw_q) begin
                        state     <= IDLE;
                        o_Release <= 1'b1;
                        o_Pressed <= 1'b0;
                        o_Held    <= 1'b0;
                        count     <= '0;
                    end else if (!i_Repeat_En) begin
                        count <= '0;
                    end else if (count == REPEAT_LAST) begin
                        o_Repeat <= 1'b1;
                        count    <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    count     <= '0;
                    o_Pressed <= 1'b0;
                    o_Held    <= 1'b0;
                end
            endcase
        end
    end
endmodule
